// File: rtl/onehot_strobe_decoder_pkg.sv
// Shared types and width helpers for the one-hot strobe decoder.
package onehot_strobe_decoder_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StStrobe
  } state_e;

  localparam int unsigned DefaultSelW = 3;

  // One-hot output width implied by a code width.
  function automatic int unsigned onehot_width(int unsigned sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/onehot_strobe_decoder_fifo.sv
// Synchronous code FIFO: push/pop with occupancy count and combinational head.
module strobe_code_fifo #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [SEL_W-1:0]           push_code,
  input  logic                       pop,
  output logic [SEL_W-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [SEL_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_code;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/onehot_strobe_decoder.sv
// Decodes buffered channel codes into one-hot strobes held for HOLD cycles each.
module onehot_strobe_decoder
  import onehot_strobe_decoder_pkg::*;
#(
  parameter int unsigned SEL_W = DefaultSelW,
  parameter int unsigned OUT_W = onehot_width(SEL_W),
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             code_valid,
  input  logic [SEL_W-1:0] code,
  output logic             code_ready,
  output logic [OUT_W-1:0] y,
  output logic             strobe_done,
  output logic             busy
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD - 1);

  if (OUT_W != onehot_width(SEL_W) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLD < 1)
  begin : g_bad_params
    $error("onehot_strobe_decoder: illegal parameter combination");
  end

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             done_q, done_d;
  logic             push, pop;
  logic [SEL_W-1:0] head;
  logic [CntW-1:0]  count;

  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign code_ready = en && (count < CntW'(DEPTH));
  assign push       = code_valid && code_ready;

  strobe_code_fifo #(
    .SEL_W (SEL_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_code (code),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    y_d     = y_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    if (!en) begin
      // Drop the in-flight strobe; queued codes stay in the FIFO.
      state_d = StIdle;
      hold_d  = '0;
      y_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (count != '0) begin
            pop     = 1'b1;
            y_d     = OUT_W'(1) << head;
            hold_d  = HoldLoad;
            done_d  = (HoldLoad == '0);
            state_d = StStrobe;
          end else begin
            y_d = '0;
          end
        end
        StStrobe: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HoldW'(1);
            done_d = (hold_q == HoldW'(1));
          end else if (count != '0) begin
            // Back-to-back reload so the output never dips to zero between codes.
            pop    = 1'b1;
            y_d    = OUT_W'(1) << head;
            hold_d = HoldLoad;
            done_d = (HoldLoad == '0);
          end else begin
            y_d     = '0;
            state_d = StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign y           = y_q;
  assign strobe_done = done_q;
  assign busy        = (state_q != StIdle) || (count != '0);

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Scoreboard bench: accepted codes queue expected strobes, a negedge monitor checks the output.
module tb_onehot_strobe_decoder;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0, code_valid = 1'b0;
  logic [SEL_W-1:0] code = '0;
  logic             code_ready, strobe_done, busy;
  logic [OUT_W-1:0] y;

  logic             en1 = 1'b0, valid1 = 1'b0;
  logic [SEL_W-1:0] code1 = '0;
  logic             ready1, done1, busy1;
  logic [OUT_W-1:0] y1;

  int checks = 0;
  int errors = 0;
  int q[$];
  int q1[$];
  int pushed = 0;
  int popped = 0;

  always #5 clk = ~clk;

  onehot_strobe_decoder #(
    .SEL_W (SEL_W), .OUT_W (OUT_W), .DEPTH (DEPTH), .HOLD (HOLD)
  ) dut (
    .clk (clk), .rst_n (rst_n), .en (en), .code_valid (code_valid), .code (code),
    .code_ready (code_ready), .y (y), .strobe_done (strobe_done), .busy (busy)
  );

  onehot_strobe_decoder #(
    .SEL_W (SEL_W), .OUT_W (OUT_W), .DEPTH (DEPTH), .HOLD (1)
  ) dut_h1 (
    .clk (clk), .rst_n (rst_n), .en (en1), .code_valid (valid1), .code (code1),
    .code_ready (ready1), .y (y1), .strobe_done (done1), .busy (busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; the model decides acceptance from its own occupancy count.
  task automatic drive(input logic e, input logic v, input logic [SEL_W-1:0] c, output bit acc);
    bit exp_ready;
    @(posedge clk);
    #2;
    en = e; code_valid = v; code = c;
    #6;
    exp_ready = e && ((pushed - popped) < DEPTH);
    check("code_ready", 32'(code_ready), 32'(exp_ready));
    acc = v && exp_ready;
    if (acc) begin
      q.push_back(int'(c));
      pushed++;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) drive(1'b1, 1'b0, '0, acc);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    code_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_y", 32'(y), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(strobe_done), 32'h0);
    check("rst_ready", 32'(code_ready), 32'(en));
    q.delete();
    pushed = 0;
    popped = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor for the HOLD=2 instance.
  logic [OUT_W-1:0] prev_y;
  logic             prev_done, last_en;
  int               cur_len, snap_pushed;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_y = '0; prev_done = 1'b0; last_en = 1'b0; cur_len = 0; snap_pushed = 0;
    end else begin
      check("y_onehot0", 32'($onehot0(y)), 32'h1);
      if (!last_en) begin
        check("y_disabled", 32'(y), 32'h0);
        check("done_disabled", 32'(strobe_done), 32'h0);
        cur_len = 0;
      end else if (y != '0) begin
        if (prev_y == '0 || prev_done) begin
          if (q.size() == 0) begin
            check("strobe_unexpected", 32'(y), 32'h0);
          end else begin
            int e;
            e = q.pop_front();
            check("strobe_code", 32'(y), 32'(8'(1) << e));
            popped++;
          end
          cur_len = 1;
        end else begin
          cur_len++;
          check("y_hold", 32'(y), 32'(prev_y));
        end
        check("strobe_done", 32'(strobe_done), 32'(cur_len == HOLD));
      end else begin
        check("done_idle", 32'(strobe_done), 32'h0);
        if (prev_y != '0) check("strobe_len", 32'(cur_len), 32'(HOLD));
        if (prev_y == '0 || prev_done) check("missed_pop", 32'(snap_pushed > popped), 32'h0);
        cur_len = 0;
      end
      check("busy", 32'(busy), 32'((y != '0) || (pushed > popped)));
      prev_y = y; prev_done = strobe_done; last_en = en; snap_pushed = pushed;
    end
  end

  // Monitor for the HOLD=1 instance.
  int run_len = 0;
  int max_run = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (y1 != '0) begin
        if (q1.size() == 0) begin
          check("h1_unexpected", 32'(y1), 32'h0);
        end else begin
          int e;
          e = q1.pop_front();
          check("h1_code", 32'(y1), 32'(8'(1) << e));
        end
        check("h1_done", 32'(done1), 32'h1);
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  initial begin
    bit acc;
    int guard;

    #1;
    check("init_y", 32'(y), 32'h0);
    check("init_busy", 32'(busy), 32'h0);
    check("init_done", 32'(strobe_done), 32'h0);
    #11;
    rst_n = 1'b1;
    en = 1'b1;
    #1;
    check("ready_after_rst", 32'(code_ready), 32'h1);

    // Single strobe.
    drive(1'b1, 1'b1, 3'd5, acc);
    idle(6);

    // Back-to-back codes.
    drive(1'b1, 1'b1, 3'd7, acc);
    drive(1'b1, 1'b1, 3'd0, acc);
    drive(1'b1, 1'b1, 3'd3, acc);
    idle(8);

    // Fill the FIFO while holding valid.
    for (int c = 1; c <= 6; c++) begin
      guard = 0;
      do begin
        drive(1'b1, 1'b1, 3'(c), acc);
        guard++;
      end while (!acc && guard < 50);
      if (!acc) check("accept_timeout", 32'h0, 32'h1);
    end
    idle(16);

    // Enable drop with codes still queued.
    drive(1'b1, 1'b1, 3'd2, acc);
    drive(1'b1, 1'b1, 3'd4, acc);
    drive(1'b1, 1'b1, 3'd6, acc);
    repeat (3) drive(1'b0, 1'b0, '0, acc);
    idle(10);

    // Asynchronous reset in the middle of a strobe.
    drive(1'b1, 1'b1, 3'd1, acc);
    drive(1'b1, 1'b1, 3'd2, acc);
    async_reset();
    idle(3);

    // Randomised traffic with occasional enable drops.
    repeat (400) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), acc);
    end
    idle(30);
    check("drain_empty", 32'(q.size()), 32'h0);

    // HOLD=1 instance: one code per cycle, walking 01..80.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #2;
      en1 = 1'b1; valid1 = 1'b1; code1 = 3'(k);
      #6;
      check("h1_ready", 32'(ready1), 32'h1);
      q1.push_back(k);
    end
    @(posedge clk);
    #2;
    valid1 = 1'b0;
    repeat (4) @(posedge clk);
    #8;
    check("h1_drained", 32'(q1.size()), 32'h0);
    check("h1_no_gap", 32'(max_run), 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_strobe_decoder.md
Name: onehot_strobe_decoder

Overview:
- Return path of the 8-input priority encoder: takes encoded 3-bit channel indices and drives the matching one-hot select line.
- Codes arrive over a valid/ready handshake and are buffered in a small FIFO.
- Each code drives its one-hot line for a programmable number of cycles before the next code is taken.
- Enable gating matches the encoder: en=0 forces all-zero output.

Parameters:
- SEL_W, 3, code width.
- OUT_W, 8, one-hot width; must equal 2**SEL_W.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- HOLD, 2, cycles each strobe is held; ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  block enable
- code_valid  in  1  code present
- code  in  SEL_W  channel index to decode
- code_ready  out  1  code accepted on the edge where code_valid && code_ready
- y  out  OUT_W  registered one-hot strobe (all zero when idle or disabled)
- strobe_done  out  1  one-cycle pulse on the last hold cycle of a strobe that completes normally
- busy  out  1  state!=IDLE or FIFO non-empty

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values, applied immediately with no clock edge:
  - y=0, strobe_done=0, state=IDLE, hold_cnt=0.
  - FIFO count=0, FIFO pointers=0.
- code_ready is combinational: en && (count < DEPTH).
  - A push is not allowed when the FIFO is full, even if a pop happens in the same cycle.
- Push and pop in the same cycle: allowed; count is unchanged.
- FIFO pointers wrap modulo DEPTH.
- State IDLE:
  - If en && count>0: pop the head and set y <= 1<<head.
  - Load hold_cnt <= HOLD-1 and go to STROBE.
  - Otherwise y=0.
- State STROBE:
  - y holds its value.
  - If hold_cnt>0: decrement hold_cnt.
  - If hold_cnt==0: assert strobe_done that cycle (registered, aligned with the last hold cycle of y).
  - At that edge, if en && count>0: pop the next code back-to-back with no zero gap, y <= new one-hot, reload hold_cnt.
  - Else y <= 0 and go to IDLE.
- Latency: a code accepted at edge k into an empty FIFO in IDLE appears on y after edge k+1.
  - It stays on y for exactly HOLD cycles.
- en deasserted in any state, at the next edge:
  - y <= 0, state <= IDLE, strobe_done <= 0.
  - The in-flight code is discarded.
  - Queued FIFO entries are retained.
  - No pushes occur, because code_ready=0.
- en reasserted: normal IDLE pop resumes on the following edge.
- HOLD=1: one code per cycle. strobe_done is asserted continuously during back-to-back strobes.
- y is never multi-hot. code values are always in range (SEL_W bits fill OUT_W exactly).

Decomposition:
- Shared package: state enum (IDLE, STROBE), and the OUT_W = 1<<SEL_W constant/check.
- Sub-module: strobe_code_fifo, a sync FIFO with push/pop/count/head, parameterised by SEL_W and DEPTH.
- FSM, hold counter and one-hot decode stay in the top level.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run, no clock edge → y=8'h00, busy=0. Release rst_n with en=1 → code_ready=1.
- Single strobe: en=1, code=5 for one cycle → y=8'h20 for exactly 2 cycles, starting after the 2nd edge; strobe_done=1 on the 2nd of those cycles; then y=0, busy=0.
- Back-to-back codes: push 7, 0, 3 on consecutive cycles → y=80, 80, 01, 01, 08, 08 with no zero gap; strobe_done pulses 3 times.
- Full FIFO: hold code_valid=1 for codes 1–6 while the first strobe is active → code_ready drops when count=4. Remaining codes are accepted as pops free space. Output order is 02, 04, 08, 10, 20, 40, with no loss or duplication.
- Enable drop: en=0 during the strobe of code 2 with codes 4 and 6 queued → y=0 on the next edge, code_ready=0, busy=1. After en=1 → y=10 then y=40; code 2 is not replayed.
- HOLD=1 build: push 0..7 continuously → y walks 01, 02, ..., 80 one per cycle; strobe_done stays high throughout.
